clock_monitor: RTL and testbench



---
 rtl/clock_monitor_if.sv | 25 ++
 rtl/clock_monitor.sv | 169 ++++++++++++++++
 tb/tb_clock_monitor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_monitor_if.sv
// Signal bundle between a monitored slow clock source and clock_monitor.
// The slave side is the monitor: it samples clk_in and drives the measurement
// results; the master side supplies clk_in and consumes the results.
`timescale 1ns/1ps
interface clock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic             timeout;
  logic [CNT_W-1:0] high_time;

  modport master (
    output clk_in,
    input  period, period_valid, locked, err, timeout, high_time
  );

  modport slave (
    input  clk_in,
    output period, period_valid, locked, err, timeout, high_time
  );
endinterface

// File: rtl/clock_monitor.sv
// Slow-clock monitor running in the clock1M domain: measures clk_in period,
// declares lock after LOCK_CNT consecutive in-tolerance periods, flags bad
// periods and loss of clock.
// Optional macro CLK_MON_DUTY_EN adds high-phase measurement on high_time;
// without it high_time is tied to 0.
//
// state  | meaning
// SEARCH | waiting for first clk_in rise; partial interval, nothing reported
// TRACK  | reporting periods, counting consecutive good ones toward lock
// LOCKED | frequency confirmed; a bad period or timeout leaves this state
`timescale 1ns/1ps
module clock_monitor #(
  parameter int EXP_PERIOD = 100,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16
) (
  input  logic            clock1M,
  input  logic            reset,
  clock_monitor_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_X     = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT);

  logic              sync1_q, sync2_q, dly_q;
  logic              rise;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]    period_ext, diff;
  logic              in_tol;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              pv_q, pv_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic              locked_q;

  // Synchronize clk_in and keep one delayed copy for edge detection.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= bus.clk_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise = sync2_q & ~dly_q;

  // Saturating period counter and the tolerance test on the would-be period.
  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    cnt_d      = rise ? '0 : cnt_inc;
    period_ext = {1'b0, cnt_inc};
    diff       = (period_ext >= EXP_X) ? (period_ext - EXP_X) : (EXP_X - period_ext);
    in_tol     = (diff <= TOL_X);
  end

  // Next-state and output decode; a rise takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      SEARCH: begin
        if (rise) state_d = TRACK;
      end
      TRACK, LOCKED: begin
        if (rise) begin
          period_d = cnt_inc;
          pv_d     = 1'b1;
          if (in_tol) begin
            if (state_q == TRACK) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == LOCK_LAST) state_d = LOCKED;
            end
          end else begin
            good_d  = '0;
            err_d   = 1'b1;
            state_d = TRACK;
          end
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          good_d  = '0;
          state_d = SEARCH;
        end
      end
      default: begin
        good_d  = '0;
        state_d = SEARCH;
      end
    endcase
  end

  // State, counters and registered outputs; locked lags state by one cycle.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
      to_q     <= to_d;
      locked_q <= (state_q == LOCKED);
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.err          = err_q;
  assign bus.timeout      = to_q;
  assign bus.locked       = locked_q;

`ifdef CLK_MON_DUTY_EN
  logic             fall;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [CNT_W-1:0] high_q;

  assign fall = ~sync2_q & dly_q;

  // High-phase counter restarts on each rise and runs while clk_in is high.
  always_comb begin
    hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 1'b1;
    if (rise)         hcnt_d = '0;
    else if (sync2_q) hcnt_d = hcnt_inc;
    else              hcnt_d = hcnt_q;
  end

  // Capture the high phase on each fall once the first rise has been seen.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (fall && (state_q != SEARCH)) high_q <= hcnt_inc;
    end
  end

  assign bus.high_time = high_q;
`else
  assign bus.high_time = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: a timestamp-based model of the monitor predicts all
// outputs every cycle; a few literal expectations pin the model itself.
`timescale 1ns/1ps
module tb_clock_monitor;
  localparam int EXP_PERIOD = 100;
  localparam int TOL        = 2;
  localparam int LOCK_CNT   = 4;
  localparam int TIMEOUT    = 1000;
  localparam int CNT_W      = 16;
  localparam int MAXV       = (1 << CNT_W) - 1;

  localparam int M_HUNT = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic clock1M = 1'b0;
  logic reset   = 1'b1;

  clock_monitor_if #(.CNT_W(CNT_W)) bus();

  clock_monitor #(
    .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock1M(clock1M),
    .reset(reset),
    .bus(bus)
  );

  always #500 clock1M = ~clock1M;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: clk_in is seen by the monitor three edges late; a rise at edge e
  // reports e minus the previous rise edge (or the reset point).
  int  e = 0, last_rise = 0;
  int  m_state = M_HUNT, m_good = 0, m_period = 0, m_high = 0;
  bit  m_pv = 0, m_err = 0, m_to = 0, m_locked = 0;
  bit  h1 = 0, h2 = 0, h3 = 0;

  always @(posedge clock1M or posedge reset) begin
    int  p, dev, pre;
    bit  r, f;
    if (reset) begin
      last_rise = e;
      m_state = M_HUNT; m_good = 0; m_period = 0; m_high = 0;
      m_pv = 0; m_err = 0; m_to = 0; m_locked = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      e++;
      r = h2 && !h3;
      f = !h2 && h3;
      pre = m_state;
      m_pv = 0; m_err = 0; m_to = 0;
      m_locked = (pre == M_LOCK);
      if (f && pre != M_HUNT) begin
        p = e - last_rise;
        m_high = (p > MAXV) ? MAXV : p;
      end
      if (r) begin
        if (pre == M_HUNT) begin
          m_state = M_ACQ;
        end else begin
          p = e - last_rise;
          if (p > MAXV) p = MAXV;
          m_period = p;
          m_pv = 1;
          dev = (p > EXP_PERIOD) ? p - EXP_PERIOD : EXP_PERIOD - p;
          if (dev <= TOL) begin
            if (pre == M_ACQ) begin
              m_good++;
              if (m_good == LOCK_CNT) m_state = M_LOCK;
            end
          end else begin
            m_good = 0; m_err = 1; m_state = M_ACQ;
          end
        end
        last_rise = e;
      end else if (pre != M_HUNT && (e - last_rise) == TIMEOUT) begin
        m_to = 1; m_good = 0; m_state = M_HUNT;
      end
      h3 = h2; h2 = h1; h1 = bus.clk_in;
    end
  end

  bit cmp_en = 0;
  int pv_cnt = 0, err_cnt = 0, to_cnt = 0;

  always @(negedge clock1M) begin
    if (cmp_en) begin
      check("period",       bus.period,       m_period);
      check("period_valid", bus.period_valid, m_pv);
      check("err",          bus.err,          m_err);
      check("timeout",      bus.timeout,      m_to);
      check("locked",       bus.locked,       m_locked);
`ifdef CLK_MON_DUTY_EN
      check("high_time",    bus.high_time,    m_high);
`else
      check("high_time",    bus.high_time,    0);
`endif
      if (bus.period_valid) pv_cnt++;
      if (bus.err)          err_cnt++;
      if (bus.timeout)      to_cnt++;
    end
  end

  task automatic run_period(input int hi, input int lo);
    bus.clk_in = 1'b1;
    repeat (hi) @(posedge clock1M);
    #1 bus.clk_in = 1'b0;
    repeat (lo) @(posedge clock1M);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock1M);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, bus.period, 0);
    check({tag, "_pv"},     bus.period_valid, 0);
    check({tag, "_locked"}, bus.locked, 0);
    check({tag, "_err"},    bus.err, 0);
    check({tag, "_to"},     bus.timeout, 0);
    check({tag, "_high"},   bus.high_time, 0);
  endtask

  initial begin
    int e0, p0, t0, p, h;
    bus.clk_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock1M);
    #1;
    check_all_zero("rst");
    cmp_en = 1;
    reset = 1'b0;
    idle(10);

    // 10 kHz, 50/50: first report on 2nd rise, lock after 4th report
    repeat (4) run_period(50, 50);
    check("tenk_pv4", pv_cnt, 3);
    check("tenk_unlocked", bus.locked, 0);
    run_period(50, 50);
    check("tenk_pv5", pv_cnt, 4);
    check("tenk_locked", bus.locked, 1);
    check("tenk_period", bus.period, 100);
    repeat (3) run_period(50, 50);
    check("tenk_no_err", err_cnt, 0);

    // 102 keeps lock, 103 breaks it, four good periods relock
    run_period(51, 51);
    run_period(52, 51);
    check("p102_period", bus.period, 102);
    check("p102_locked", bus.locked, 1);
    e0 = err_cnt;
    run_period(50, 50);
    check("p103_period", bus.period, 103);
    check("p103_unlocked", bus.locked, 0);
    check("p103_err", err_cnt - e0, 1);
    repeat (3) run_period(50, 50);
    check("relock_not_yet", bus.locked, 0);
    run_period(50, 50);
    check("relock", bus.locked, 1);

    // 100 kHz: every period is out of tolerance
    e0 = err_cnt;
    repeat (10) run_period(5, 5);
    check("hundk_period", bus.period, 10);
    check("hundk_err", err_cnt - e0, 9);
    check("hundk_locked", bus.locked, 0);

    // randomized periods around and away from nominal
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) p = $urandom_range(8, 30);
      else                           p = $urandom_range(95, 105);
      h = $urandom_range(1, p - 1);
      run_period(h, p - h);
    end

    // relock, then lose the clock
    repeat (6) run_period(50, 50);
    check("pre_to_locked", bus.locked, 1);
    t0 = to_cnt;
    idle(1000);
    check("to_pulse", to_cnt - t0, 1);
    check("to_unlocked", bus.locked, 0);
    p0 = pv_cnt;
    run_period(49, 49);
    check("post_to_silent", pv_cnt - p0, 0);
    run_period(50, 50);
    check("post_to_pv", pv_cnt - p0, 1);
    check("post_to_period", bus.period, 98);

    // rise exactly when the timeout would fire: rise wins
    t0 = to_cnt;
    run_period(500, 500);
    run_period(5, 5);
    check("edge_1000_no_to", to_cnt - t0, 0);
    check("edge_1000_period", bus.period, 1000);
    // one cycle longer: timeout fires first, next rise only restarts
    p0 = pv_cnt;
    run_period(500, 501);
    run_period(5, 5);
    check("edge_1001_to", to_cnt - t0, 1);
    check("edge_1001_pv", pv_cnt - p0, 1);

    // reset in the middle of a locked high phase
    repeat (6) run_period(50, 50);
    check("pre_rst_locked", bus.locked, 1);
    bus.clk_in = 1'b1;
    idle(20);
    reset = 1'b1;
    bus.clk_in = 1'b0;
    #1;
    check_all_zero("midrst");
    idle(3);
    reset = 1'b0;
    repeat (4) run_period(50, 50);
    check("post_rst_unlocked", bus.locked, 0);
    run_period(50, 50);
    check("post_rst_locked", bus.locked, 1);

    // 30/70 duty
    repeat (3) run_period(30, 70);
    check("duty_period", bus.period, 100);
`ifdef CLK_MON_DUTY_EN
    check("duty_high", bus.high_time, 30);
`else
    check("duty_high", bus.high_time, 0);
`endif
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
